alu_issue_stage: RTL and testbench
==================================

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock; rst  input  1  synchronous active-high reset.
REQ-002 in_valid  input  1  upstream decode slot holds an instruction.
REQ-003 in_ready  output  1  stage can accept; registered, equals NOT skid_full.
REQ-004 in_opcode  input  7  instruction[6:0].
REQ-005 in_funct3  input  3  instruction[14:12].
REQ-006 in_funct7b5  input  1  instruction[30].
REQ-007 in_rs1_data, in_rs2_data, in_imm  input  32 each  register-file operands and sign-extended immediate.
REQ-008 in_rd  input  5  destination register index.
REQ-009 flush  input  1  branch-mispredict squash.
REQ-010 out_valid  output  1  execute slot holds a valid operation.
REQ-011 out_ready  input  1  execute stage accepts; low means stall.
REQ-012 out_alu_control  output  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-013 out_src_a, out_src_b  output  32 each  ALU A and B operands.
REQ-014 out_rd  output  5; out_illegal  output  1  unsupported encoding.

Function
REQ-015 Decode: opcode 0110011 SHALL map funct3/funct7b5 as 000/0 to 000, 000/1 to 001, 111 to 010, 110 to 011, 010 to 101, with src_b = rs2_data.
REQ-016 Decode: opcode 0010011 SHALL map funct3 as 000 to 000, 111 to 010, 110 to 011, 010 to 101, ignoring funct7b5, with src_b = imm.
REQ-017 Decode: opcodes 0000011 and 0100011 SHALL produce 000 with src_b = imm; opcode 1100011 SHALL produce 001 with src_b = rs2_data.
REQ-018 Any other opcode or unlisted funct3 SHALL produce illegal=1, alu_control=000, src_b=rs2_data, with the entry still passed downstream; src_a SHALL always be rs1_data.
REQ-019 Transfer rules: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
REQ-020 Storage SHALL be two entries: main (drives outputs) and skid; decode SHALL occur before storage, and outputs SHALL be driven directly from flops.
REQ-021 Latency: in_fire into an empty stage SHALL give out_valid=1 on the next cycle; sustained throughput SHALL be 1 op/cycle while out_ready=1.
REQ-022 Main SHALL load when it is empty or out_fire, taking skid if skid is full, else the input if in_fire; otherwise main holds.
REQ-023 Skid SHALL load on in_fire when main is full and no out_fire occurs, or when main refills from skid in the same cycle as in_fire; skid SHALL empty when moved to main.
REQ-024 Ordering SHALL be strict FIFO, with no drop or duplication.
REQ-025 While out_valid=1 and out_ready=0, all out_* signals SHALL hold stable.
REQ-026 Both full with out_ready=0: in_ready SHALL be 0; any in_valid SHALL be ignored and SHALL NOT corrupt state.
REQ-027 Flush SHALL take effect at the next clock edge: both entries cleared, out_valid=0, in_ready=1; an in_fire in the flush cycle SHALL be discarded.
REQ-028 Priority SHALL be rst, then flush, then normal operation.

Reset
REQ-029 rst=1 at a clock edge SHALL set out_valid=0, in_ready=1, skid empty, and out_alu_control, out_src_a, out_src_b, out_rd, out_illegal to 0.
REQ-030 Reset asserted mid-stall SHALL discard both entries; the first in_fire after release SHALL appear as the first output.

Verification
REQ-031 Scenario: add x3 = 5 + 7 (opcode 0110011, f3 000, f7b5 0, rs1=5, rs2=7, rd=3), out_ready=1 -> next cycle out_valid=1, alu_control=000, A=5, B=7, rd=3, illegal=0.
REQ-032 Scenario: back-to-back sub, andi (imm=0xF0), slt, lw (imm=8) -> alu_control sequence 001, 010, 011-free 101, 000 on consecutive cycles; B=imm for andi and lw.
REQ-033 Scenario: out_ready=0 for 3 cycles while feeding 3 ops -> after 2 accepted, in_ready=0; on release, outputs op1 then op2 in order, and op3 is accepted afterwards.
REQ-034 Scenario: opcode 1110011 -> illegal=1, alu_control=000; funct3 001 with R-type -> illegal=1.
REQ-035 Scenario: both entries full, assert flush together with in_valid -> next cycle out_valid=0, in_ready=1, no later output of the flushed or concurrent ops.
REQ-036 Scenario: rst pulse during a stall with 2 entries held -> all outputs 0, in_ready=1; then beq with rs1=rs2=9 -> alu_control=001, A=9, B=9.

Source files
------------

// File: rtl/alu_issue_stage_if.sv
// ---------------------------------------------------------------------------
// alu_issue_stage_if : decode-slot to execute-slot handshake bundle | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface alu_issue_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic        in_funct7b5;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic [31:0] in_imm;
  logic [4:0]  in_rd;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_alu_control;
  logic [31:0] out_src_a;
  logic [31:0] out_src_b;
  logic [4:0]  out_rd;
  logic        out_illegal;

  modport master (
    output in_valid, in_opcode, in_funct3, in_funct7b5, in_rs1_data,
           in_rs2_data, in_imm, in_rd, flush, out_ready,
    input  in_ready, out_valid, out_alu_control, out_src_a, out_src_b,
           out_rd, out_illegal
  );

  modport slave (
    input  in_valid, in_opcode, in_funct3, in_funct7b5, in_rs1_data,
           in_rs2_data, in_imm, in_rd, flush, out_ready,
    output in_ready, out_valid, out_alu_control, out_src_a, out_src_b,
           out_rd, out_illegal
  );
endinterface

`default_nettype wire

// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage : ALU decode + two-entry skid buffer issue slot | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_issue_stage (
  input  wire logic         clk,
  input  wire logic         rst,
  alu_issue_stage_if.slave  bus
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef struct packed {
    logic [2:0]  ctrl;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [4:0]  rd;
    logic        illegal;
  } entry_t;

  entry_t dec;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   in_fire;
  logic   out_fire;
  logic   main_take;

  always_comb begin
    dec         = '0;
    dec.ctrl    = ALU_ADD;
    dec.src_a   = bus.in_rs1_data;
    dec.src_b   = bus.in_rs2_data;
    dec.rd      = bus.in_rd;
    dec.illegal = 1'b0;
    case (bus.in_opcode)
      OP_R: begin
        case (bus.in_funct3)
          3'b000:  dec.ctrl = bus.in_funct7b5 ? ALU_SUB : ALU_ADD;
          3'b111:  dec.ctrl = ALU_AND;
          3'b110:  dec.ctrl = ALU_OR;
          3'b010:  dec.ctrl = ALU_SLT;
          default: dec.illegal = 1'b1;
        endcase
      end
      OP_I: begin
        dec.src_b = bus.in_imm;
        case (bus.in_funct3)
          3'b000:  dec.ctrl = ALU_ADD;
          3'b111:  dec.ctrl = ALU_AND;
          3'b110:  dec.ctrl = ALU_OR;
          3'b010:  dec.ctrl = ALU_SLT;
          default: begin
            dec.illegal = 1'b1;
            dec.src_b   = bus.in_rs2_data;
          end
        endcase
      end
      OP_LOAD, OP_STORE: dec.src_b = bus.in_imm;
      OP_BRANCH:         dec.ctrl  = ALU_SUB;
      default:           dec.illegal = 1'b1;
    endcase
  end

  // in_ready comes straight from the skid flop, so it is registered by construction.
  assign in_fire   = bus.in_valid & ~skid_valid_q;
  assign out_fire  = main_valid_q & bus.out_ready;
  assign main_take = ~main_valid_q | out_fire;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (main_take) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        main_d       = dec;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end
    if (in_fire && (!main_take || skid_valid_q)) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
    if (bus.flush) begin
      main_d       = '0;
      skid_d       = '0;
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign bus.in_ready        = ~skid_valid_q;
  assign bus.out_valid       = main_valid_q;
  assign bus.out_alu_control = main_q.ctrl;
  assign bus.out_src_a       = main_q.src_a;
  assign bus.out_src_b       = main_q.src_b;
  assign bus.out_rd          = main_q.rd;
  assign bus.out_illegal     = main_q.illegal;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_stage : random + directed check against a 2-deep FIFO model | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_alu_issue_stage;

  typedef struct {
    logic [2:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t q[$];
  logic [6:0] ops[8];

  alu_issue_stage_if bus ();

  alu_issue_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // The issue stage behaves as a 2-deep FIFO of decoded instructions.
  function automatic exp_t decode(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                                  input logic [31:0] rs1, input logic [31:0] rs2,
                                  input logic [31:0] imm, input logic [4:0] rd);
    exp_t e;
    e.a = rs1; e.rd = rd; e.ctrl = 3'b000; e.b = rs2; e.ill = 1'b0;
    if (opc == 7'b0110011 || opc == 7'b0010011) begin
      if      (f3 == 3'b000) e.ctrl = (opc == 7'b0110011 && f7) ? 3'b001 : 3'b000;
      else if (f3 == 3'b111) e.ctrl = 3'b010;
      else if (f3 == 3'b110) e.ctrl = 3'b011;
      else if (f3 == 3'b010) e.ctrl = 3'b101;
      else e.ill = 1'b1;
      if (opc == 7'b0010011 && !e.ill) e.b = imm;
    end else if (opc == 7'b0000011 || opc == 7'b0100011) begin
      e.b = imm;
    end else if (opc == 7'b1100011) begin
      e.ctrl = 3'b001;
    end else begin
      e.ill = 1'b1;
    end
    return e;
  endfunction

  always @(posedge clk) begin
    if (rst || bus.flush) begin
      q.delete();
    end else begin
      automatic bit can_push = (q.size() < 2);
      if (q.size() > 0 && bus.out_ready) void'(q.pop_front());
      if (bus.in_valid && can_push)
        q.push_back(decode(bus.in_opcode, bus.in_funct3, bus.in_funct7b5,
                           bus.in_rs1_data, bus.in_rs2_data, bus.in_imm, bus.in_rd));
    end
  end

  always @(negedge clk) begin
    chk("in_ready", {31'b0, bus.in_ready}, {31'b0, q.size() < 2});
    chk("out_valid", {31'b0, bus.out_valid}, {31'b0, q.size() > 0});
    if (q.size() > 0) begin
      chk("alu_control", {29'b0, bus.out_alu_control}, {29'b0, q[0].ctrl});
      chk("src_a", bus.out_src_a, q[0].a);
      chk("src_b", bus.out_src_b, q[0].b);
      chk("rd", {27'b0, bus.out_rd}, {27'b0, q[0].rd});
      chk("illegal", {31'b0, bus.out_illegal}, {31'b0, q[0].ill});
    end
  end

  task automatic set_op(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                        input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [31:0] imm, input logic [4:0] rd);
    bus.in_valid    = 1'b1;
    bus.in_opcode   = opc;
    bus.in_funct3   = f3;
    bus.in_funct7b5 = f7;
    bus.in_rs1_data = rs1;
    bus.in_rs2_data = rs2;
    bus.in_imm      = imm;
    bus.in_rd       = rd;
  endtask

  task automatic chk_all_zero();
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("rst_alu_control", {29'b0, bus.out_alu_control}, 32'd0);
    chk("rst_src_a", bus.out_src_a, 32'd0);
    chk("rst_src_b", bus.out_src_b, 32'd0);
    chk("rst_rd", {27'b0, bus.out_rd}, 32'd0);
    chk("rst_illegal", {31'b0, bus.out_illegal}, 32'd0);
  endtask

  initial begin
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
            7'b1100011, 7'b1110011, 7'b0110111, 7'b0110011};
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    set_op(7'b0, 3'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero();
    rst = 1'b0;

    // add x3 = 5 + 7
    set_op(7'b0110011, 3'b000, 1'b0, 32'd5, 32'd7, 32'd99, 5'd3);
    @(negedge clk);
    chk("add_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("add_ctrl", {29'b0, bus.out_alu_control}, 32'd0);
    chk("add_a", bus.out_src_a, 32'd5);
    chk("add_b", bus.out_src_b, 32'd7);
    chk("add_rd", {27'b0, bus.out_rd}, 32'd3);
    chk("add_ill", {31'b0, bus.out_illegal}, 32'd0);

    // back-to-back sub, andi, slt, lw
    set_op(7'b0110011, 3'b000, 1'b1, 32'd20, 32'd4, 32'd0, 5'd1);
    @(negedge clk);
    chk("sub_ctrl", {29'b0, bus.out_alu_control}, 32'd1);
    set_op(7'b0010011, 3'b111, 1'b1, 32'hFF, 32'd4, 32'hF0, 5'd2);
    @(negedge clk);
    chk("andi_ctrl", {29'b0, bus.out_alu_control}, 32'd2);
    chk("andi_b", bus.out_src_b, 32'hF0);
    set_op(7'b0110011, 3'b010, 1'b0, 32'd1, 32'd2, 32'd0, 5'd4);
    @(negedge clk);
    chk("slt_ctrl", {29'b0, bus.out_alu_control}, 32'd5);
    set_op(7'b0000011, 3'b010, 1'b0, 32'h100, 32'd3, 32'd8, 5'd5);
    @(negedge clk);
    chk("lw_ctrl", {29'b0, bus.out_alu_control}, 32'd0);
    chk("lw_b", bus.out_src_b, 32'd8);
    bus.in_valid = 1'b0;
    @(negedge clk);

    // stall with three ops offered
    bus.out_ready = 1'b0;
    set_op(7'b0110011, 3'b110, 1'b0, 32'd1, 32'd2, 32'd0, 5'd10);
    @(negedge clk);
    set_op(7'b0110011, 3'b111, 1'b0, 32'd3, 32'd4, 32'd0, 5'd11);
    @(negedge clk);
    chk("stall_in_ready", {31'b0, bus.in_ready}, 32'd0);
    chk("stall_rd_op1", {27'b0, bus.out_rd}, 32'd10);
    set_op(7'b0010011, 3'b000, 1'b0, 32'd5, 32'd6, 32'd7, 5'd12);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("rel_rd_op2", {27'b0, bus.out_rd}, 32'd11);
    @(negedge clk);
    chk("rel_rd_op3", {27'b0, bus.out_rd}, 32'd12);
    bus.in_valid = 1'b0;
    @(negedge clk);

    // illegal encodings
    set_op(7'b1110011, 3'b000, 1'b0, 32'd1, 32'd2, 32'd3, 5'd6);
    @(negedge clk);
    chk("ecall_ill", {31'b0, bus.out_illegal}, 32'd1);
    chk("ecall_ctrl", {29'b0, bus.out_alu_control}, 32'd0);
    set_op(7'b0110011, 3'b001, 1'b0, 32'd1, 32'd2, 32'd3, 5'd7);
    @(negedge clk);
    chk("sll_ill", {31'b0, bus.out_illegal}, 32'd1);
    bus.in_valid = 1'b0;
    @(negedge clk);

    // flush with both entries full and a concurrent offer
    bus.out_ready = 1'b0;
    set_op(7'b0110011, 3'b000, 1'b0, 32'd1, 32'd1, 32'd0, 5'd20);
    @(negedge clk);
    set_op(7'b0110011, 3'b000, 1'b0, 32'd2, 32'd2, 32'd0, 5'd21);
    @(negedge clk);
    set_op(7'b0110011, 3'b000, 1'b0, 32'd3, 32'd3, 32'd0, 5'd22);
    bus.flush = 1'b1;
    @(negedge clk);
    chk("flush_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("flush_ready", {31'b0, bus.in_ready}, 32'd1);
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // reset during a full stall, then beq
    bus.out_ready = 1'b0;
    set_op(7'b0010011, 3'b110, 1'b0, 32'd8, 32'd8, 32'd8, 5'd30);
    @(negedge clk);
    set_op(7'b0010011, 3'b111, 1'b0, 32'd9, 32'd9, 32'd9, 5'd31);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_all_zero();
    bus.out_ready = 1'b1;
    set_op(7'b1100011, 3'b000, 1'b0, 32'd9, 32'd9, 32'h123, 5'd0);
    @(negedge clk);
    chk("beq_ctrl", {29'b0, bus.out_alu_control}, 32'd1);
    chk("beq_a", bus.out_src_a, 32'd9);
    chk("beq_b", bus.out_src_b, 32'd9);
    bus.in_valid = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 3000; i++) begin
      set_op(ops[$urandom_range(0, 7)], 3'($urandom), 1'($urandom),
             $urandom, $urandom, $urandom, 5'($urandom));
      if ($urandom_range(0, 15) == 0) bus.in_opcode = 7'($urandom);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.flush     = ($urandom_range(0, 40) == 0);
      rst           = ($urandom_range(0, 150) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
